// File: rtl/img_fb_pkg.sv
// Shared types and defaults for the image frame buffer.
package img_fb_pkg;

    localparam int DEFAULT_FRAME_WORDS = 22500;  // 300*300 pixels, 4 per word
    localparam int DEFAULT_ADDR_W      = 16;
    localparam int DEFAULT_CKSUM_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PROC  = 2'd2,
        DRAIN = 2'd3
    } fb_state_t;

    // Pixel idx of a word; idx 0 is the leftmost pixel in [31:24].
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/img_word_ram.sv
// 32-bit word RAM: one write port, one registered read port.
// Out-of-range writes are dropped; out-of-range reads leave rdata unchanged.
module img_word_ram
    import img_fb_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_FRAME_WORDS,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    localparam int                IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    logic [31:0] mem [0:DEPTH-1];

    // Write port, guarded against addresses past the end of the array.
    always_ff @(posedge clk) begin
        if (we && waddr <= LAST)
            mem[waddr[IDX_W-1:0]] <= wdata;
    end

    // Registered read port; contents are never reset.
    always_ff @(posedge clk) begin
        if (raddr <= LAST)
            rdata <= mem[raddr[IDX_W-1:0]];
    end

endmodule

// File: rtl/img_frame_buffer.sv
// Frame buffer around the kernel image processor: byte-stream load into
// in_ram, processor read/write ports, byte-stream drain from out_ram.
// Optional feature macro: IMG_FB_CKSUM_EN adds the out_cksum running sum.
module img_frame_buffer
    import img_fb_pkg::*;
#(
    parameter int FRAME_WORDS = DEFAULT_FRAME_WORDS,
    parameter int ADDR_W      = DEFAULT_ADDR_W
`ifdef IMG_FB_CKSUM_EN
    ,
    parameter int CKSUM_W     = DEFAULT_CKSUM_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              basla,
    input  logic [ADDR_W-1:0] oku_adres,
    output logic [31:0]       oku_veri,
    input  logic [ADDR_W-1:0] yaz_adres,
    input  logic [31:0]       yaz_veri,
    input  logic              yaz_gecerli,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done,
`ifdef IMG_FB_CKSUM_EN
    output logic [CKSUM_W-1:0] out_cksum,
`endif
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);

    fb_state_t         state, state_nx;
    logic [ADDR_W-1:0] wcnt, rcnt;
    logic [1:0]        in_lane, out_lane;
    logic [23:0]       pack;
    logic [31:0]       in_rdata, out_rdata;
    logic              oku_zero;

    logic              in_acc, in_we, load_last;
    logic              yaz_ok, proc_last;
    logic              out_acc, drain_last;
    logic [ADDR_W-1:0] out_raddr;

    assign in_acc     = in_valid && in_ready;
    assign in_we      = in_acc && (in_lane == 2'd3);
    assign load_last  = in_we && (wcnt == LAST);
    assign yaz_ok     = (state == PROC) && yaz_gecerli && (yaz_adres <= LAST);
    assign proc_last  = yaz_ok && (yaz_adres == LAST);
    assign out_acc    = out_valid && out_ready;
    assign drain_last = out_acc && (out_lane == 2'd3) && (rcnt == LAST);

    // Fetch the next word as soon as byte 3 is taken, so the following
    // cycle already presents byte 0 of the next word; a stalled byte 3
    // keeps the current word on the RAM output.
    assign out_raddr  = (out_acc && out_lane == 2'd3) ? rcnt + 1'b1 : rcnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_acc)     state_nx = LOAD;
            LOAD:    if (load_last)  state_nx = PROC;
            PROC:    if (proc_last)  state_nx = DRAIN;
            DRAIN:   if (drain_last) state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready = 1'b0;
        basla    = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE:    in_ready = 1'b1;
            LOAD:    in_ready = 1'b1;
            PROC:    basla    = 1'b1;
            default: ;
        endcase
    end

    // Load side: pack bytes big-endian, write every 4th, count words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt    <= '0;
            in_lane <= 2'd0;
            pack    <= '0;
        end else if (in_acc) begin
            in_lane <= in_lane + 2'd1;
            pack    <= {pack[15:0], in_data};
            if (in_lane == 2'd3)
                wcnt <= load_last ? '0 : wcnt + 1'b1;
        end
    end

    img_word_ram #(.DEPTH(FRAME_WORDS), .ADDR_W(ADDR_W)) in_ram (
        .clk   (clk),
        .we    (in_we),
        .waddr (wcnt),
        .wdata ({pack, in_data}),
        .raddr (oku_adres),
        .rdata (in_rdata)
    );

    // Out-of-range processor reads return zero, aligned with the RAM latency.
    always_ff @(posedge clk) begin
        if (rst) oku_zero <= 1'b1;
        else     oku_zero <= (oku_adres > LAST);
    end

    assign oku_veri = oku_zero ? 32'd0 : in_rdata;

    img_word_ram #(.DEPTH(FRAME_WORDS), .ADDR_W(ADDR_W)) out_ram (
        .clk   (clk),
        .we    (yaz_ok),
        .waddr (yaz_adres),
        .wdata (yaz_veri),
        .raddr (out_raddr),
        .rdata (out_rdata)
    );

    // Drain side: the first DRAIN cycle only fetches word 0, so valid rises
    // one cycle later; the last accepted byte yields the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt       <= '0;
            out_lane   <= 2'd0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= drain_last;
            out_valid  <= (state == DRAIN) && !drain_last;
            if (out_acc) begin
                out_lane <= out_lane + 2'd1;
                if (out_lane == 2'd3)
                    rcnt <= drain_last ? '0 : rcnt + 1'b1;
            end
        end
    end

    assign out_data = out_valid ? byte_lane(out_rdata, out_lane) : 8'h00;

`ifdef IMG_FB_CKSUM_EN
    // Running byte sum of the drained frame; cleared when DRAIN starts.
    always_ff @(posedge clk) begin
        if (rst)            out_cksum <= '0;
        else if (proc_last) out_cksum <= '0;
        else if (out_acc)   out_cksum <= out_cksum + CKSUM_W'(out_data);
    end
`endif

endmodule
